// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM states and fault causes.
// Fault cause is kept for debug visibility; it never leaves the block as a port.
package pc_seq_pkg;

  localparam int SIZE_DEFAULT = 32;
  localparam int ADDR_W       = $clog2(SIZE_DEFAULT);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_e;

  typedef enum logic [2:0] {
    NONE,
    BAD_TARGET,
    CONFLICT,
    OVERFLOW,
    UNDERFLOW
  } faultCause_e;

endpackage

// File: rtl/pc_sequencer_call_stack.sv
// LIFO of return addresses for the sequencer's hardware call/return stack.
// Push on a full stack and pop on an empty stack are ignored; the parent faults first.
module call_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH + 1);

  logic [PW-1:0]    ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign full_o  = (ptr_q == PW'(DEPTH));
  assign empty_o = (ptr_q == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (push_i && !full_o) begin
      ptr_q <= ptr_q + PW'(1);
    end else if (pop_i && !empty_o) begin
      ptr_q <= ptr_q - PW'(1);
    end
  end

  // Entry storage needs no reset: the pointer alone defines what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_i && !full_o && (ptr_q == PW'(i))) begin
        mem_q[i] <= data_i;
      end
    end
  end

  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr_q == PW'(i + 1)) begin
        top_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage driving the fetch controller: increment, stall, jump, halt.
// Define CALL_STACK_EN to add the hardware call/return stack (call_stack sub-module).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int SIZE        = SIZE_DEFAULT,
  parameter int STACK_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall_i,
  input  logic                     jump_i,
  input  logic                     call_i,
  input  logic                     ret_i,
  input  logic                     halt_i,
  input  logic [$clog2(SIZE)-1:0]  target_i,
  output logic [$clog2(SIZE)-1:0]  pc_o,
  output logic                     pc_valid_o,
  output logic                     halted_o,
  output logic                     fault_o
);

  localparam int AW = $clog2(SIZE);

  state_e      state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  faultCause_e cause;

  logic          badTarget;
  logic [AW-1:0] pcInc;
  logic          retReq;
  logic          stackPush, stackPop, stackFull, stackEmpty;
  logic [AW-1:0] stackTop;

  // Wrap is an explicit compare so non-power-of-two depths work.
  assign pcInc     = (pc_q == AW'(SIZE - 1)) ? '0 : pc_q + AW'(1);
  assign badTarget = (int'(target_i) >= SIZE);

`ifdef CALL_STACK_EN
  assign retReq = ret_i;

  call_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (AW)
  ) u_call_stack (
    .clk     (clk),
    .reset   (reset),
    .push_i  (stackPush),
    .pop_i   (stackPop),
    .data_i  (pcInc),
    .top_o   (stackTop),
    .full_o  (stackFull),
    .empty_o (stackEmpty)
  );
`else
  localparam int unusedDepth = STACK_DEPTH;
  logic unusedStack;

  assign retReq      = 1'b0;
  assign stackFull   = 1'b0;
  assign stackEmpty  = 1'b0;
  assign stackTop    = '0;
  assign unusedStack = ^{stackPush, stackPop, ret_i, unusedDepth[0]};
`endif

  always_comb begin
    cause = NONE;
    if ((jump_i || call_i) && badTarget) begin
      cause = BAD_TARGET;
    end else if (call_i && retReq) begin
      cause = CONFLICT;
    end else if (call_i && stackFull) begin
      cause = OVERFLOW;
    end else if (retReq && stackEmpty) begin
      cause = UNDERFLOW;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // Redirects sit above stall in the chain, so they override it.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fault_d   = fault_q;
    stackPush = 1'b0;
    stackPop  = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (halt_i) begin
          state_d = HALT;
        end else if (cause != NONE) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else if (retReq) begin
          stackPop = 1'b1;
          pc_d     = stackTop;
        end else if (call_i) begin
          stackPush = 1'b1;
          pc_d      = target_i;
        end else if (jump_i) begin
          pc_d = target_i;
        end else if (!stall_i) begin
          pc_d = pcInc;
        end
      end
      HALT: state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = (state_q == RUN);
  assign halted_o   = (state_q == HALT);
  assign fault_o    = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: two instances (SIZE 32 and 20) against a
// behavioural model; CALL_STACK_EN selects the stack-enabled expectations.
module tb_pc_sequencer;

  localparam int SIZE_A = 32;
  localparam int SIZE_B = 20;
  localparam int DEPTH  = 2;
  localparam int AW     = 5;
`ifdef CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, stall, jump, call, ret, halt;
  logic [AW-1:0] target;
  logic [AW-1:0] pcA, pcB;
  logic          validA, validB, haltedA, haltedB, faultA, faultB;

  int checks = 0;
  int errors = 0;

  int mPc[2], mPhase[2], mFault[2], mSp[2];
  int mStk[2][DEPTH];
  int sizes[2];

  always #5 clk = ~clk;

  pc_sequencer #(.SIZE(SIZE_A), .STACK_DEPTH(DEPTH)) dutA (
    .clk(clk), .reset(reset), .stall_i(stall), .jump_i(jump), .call_i(call),
    .ret_i(ret), .halt_i(halt), .target_i(target), .pc_o(pcA),
    .pc_valid_o(validA), .halted_o(haltedA), .fault_o(faultA)
  );

  pc_sequencer #(.SIZE(SIZE_B), .STACK_DEPTH(DEPTH)) dutB (
    .clk(clk), .reset(reset), .stall_i(stall), .jump_i(jump), .call_i(call),
    .ret_i(ret), .halt_i(halt), .target_i(target), .pc_o(pcB),
    .pc_valid_o(validB), .halted_o(haltedB), .fault_o(faultB)
  );

  // Phases: 0 = boot, 1 = run, 2 = halt.
  task automatic modelStep(input int k);
    int s;
    bit isFault;
    s = sizes[k];
    isFault = 1'b0;
    if (!reset) begin
      mPc[k] = 0; mPhase[k] = 0; mFault[k] = 0; mSp[k] = 0;
    end else if (mPhase[k] == 0) begin
      mPhase[k] = 1;
    end else if (mPhase[k] == 1) begin
      if ((jump || call) && int'(target) >= s) isFault = 1'b1;
      if (STACK_EN) begin
        if (call && ret) isFault = 1'b1;
        if (call && mSp[k] == DEPTH) isFault = 1'b1;
        if (ret && mSp[k] == 0) isFault = 1'b1;
      end
      if (halt) begin
        mPhase[k] = 2;
      end else if (isFault) begin
        mFault[k] = 1; mPhase[k] = 2;
      end else if (STACK_EN && ret) begin
        mSp[k] = mSp[k] - 1;
        mPc[k] = mStk[k][mSp[k]];
      end else if (call) begin
        if (STACK_EN) begin
          mStk[k][mSp[k]] = (mPc[k] + 1) % s;
          mSp[k] = mSp[k] + 1;
        end
        mPc[k] = int'(target);
      end else if (jump) begin
        mPc[k] = int'(target);
      end else if (!stall) begin
        mPc[k] = (mPc[k] + 1) % s;
      end
    end
  endtask

  task automatic expectVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    expectVal({tag, ".A.pc"},     32'(pcA),     32'(mPc[0]));
    expectVal({tag, ".A.valid"},  32'(validA),  32'(mPhase[0] == 1));
    expectVal({tag, ".A.halted"}, 32'(haltedA), 32'(mPhase[0] == 2));
    expectVal({tag, ".A.fault"},  32'(faultA),  32'(mFault[0]));
    expectVal({tag, ".B.pc"},     32'(pcB),     32'(mPc[1]));
    expectVal({tag, ".B.valid"},  32'(validB),  32'(mPhase[1] == 1));
    expectVal({tag, ".B.halted"}, 32'(haltedB), 32'(mPhase[1] == 2));
    expectVal({tag, ".B.fault"},  32'(faultB),  32'(mFault[1]));
  endtask

  task automatic applyStimulus(input bit rst, input bit st, input bit jp, input bit cl,
                               input bit rt, input bit hl, input int tgt, input string tag);
    reset  = rst; stall = st; jump = jp; call = cl; ret = rt; halt = hl;
    target = AW'(tgt);
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, "reset");
  endtask

  initial begin
    bit rnd;
    sizes[0] = SIZE_A; sizes[1] = SIZE_B;
    for (int k = 0; k < 2; k++) begin
      mPc[k] = 0; mPhase[k] = 0; mFault[k] = 0; mSp[k] = 0;
    end
    reset = 1'b0; stall = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; halt = 1'b0;
    target = '0;

    $display("[TB] free run and wrap");
    doReset();
    doReset();
    expectVal("reset.pc", 32'(pcA), 0);
    expectVal("reset.valid", 32'(validA), 0);
    idle(1, "boot");
    expectVal("boot.valid", 32'(validA), 1);
    expectVal("boot.pc", 32'(pcA), 0);
    idle(31, "count");
    expectVal("count.last", 32'(pcA), 31);
    idle(1, "wrap");
    expectVal("wrap.A", 32'(pcA), 0);
    expectVal("wrap.B", 32'(pcB), 12);

    $display("[TB] stall and jump over stall");
    doReset();
    idle(6, "toFive");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, "stall");
    expectVal("stall.hold", 32'(pcA), 5);
    idle(1, "afterStall");
    expectVal("afterStall.pc", 32'(pcA), 6);
    applyStimulus(1, 1, 1, 0, 0, 0, 20, "stallJump");
    expectVal("stallJump.A", 32'(pcA), 20);
    expectVal("stallJump.Bfault", 32'(faultB), 1);
    idle(1, "afterJump");

    $display("[TB] bad target and halt");
    doReset();
    idle(1, "boot2");
    applyStimulus(1, 0, 1, 0, 0, 0, 25, "badTgt");
    expectVal("badTgt.Bpc", 32'(pcB), 0);
    expectVal("badTgt.Bhalted", 32'(haltedB), 1);
    applyStimulus(1, 0, 1, 0, 0, 0, 3, "jump3");
    applyStimulus(1, 0, 0, 0, 0, 1, 0, "halt");
    expectVal("halt.Afault", 32'(faultA), 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 9, "ignored");
    expectVal("ignored.Apc", 32'(pcA), 3);

    $display("[TB] call and return");
    doReset();
    idle(4, "toThree");
    applyStimulus(1, 0, 0, 1, 0, 0, 10, "call10");
    expectVal("call10.pc", 32'(pcA), 10);
    idle(2, "toTwelve");
    applyStimulus(1, 0, 0, 1, 0, 0, 20, "call20");
    applyStimulus(1, 0, 0, 0, 1, 0, 0, "ret1");
`ifdef CALL_STACK_EN
    expectVal("ret1.pc", 32'(pcA), 13);
`else
    expectVal("ret1.pc", 32'(pcA), 21);
`endif
    applyStimulus(1, 0, 0, 0, 1, 0, 0, "ret2");
    applyStimulus(1, 0, 0, 0, 1, 0, 0, "ret3");
`ifdef CALL_STACK_EN
    expectVal("underflow.fault", 32'(faultA), 1);
`else
    expectVal("retIgnored.pc", 32'(pcA), 23);
`endif

    doReset();
    idle(1, "boot3");
    applyStimulus(1, 0, 0, 1, 0, 0, 5, "push1");
    applyStimulus(1, 0, 0, 1, 0, 0, 6, "push2");
    applyStimulus(1, 0, 0, 1, 0, 0, 7, "push3");
`ifdef CALL_STACK_EN
    expectVal("overflow.pc", 32'(pcA), 6);
`else
    expectVal("callAsJump.pc", 32'(pcA), 7);
`endif

    $display("[TB] call with ret");
    doReset();
    idle(1, "boot4");
    applyStimulus(1, 0, 0, 1, 1, 0, 7, "callRet");
    applyStimulus(1, 0, 0, 0, 1, 0, 0, "retAlone");

    $display("[TB] reset mid-run");
    doReset();
    idle(1, "boot5");
    applyStimulus(1, 0, 0, 1, 0, 0, 16, "call16");
    idle(1, "to17");
    expectVal("to17.pc", 32'(pcA), 17);
    doReset();
    expectVal("midReset.pc", 32'(pcA), 0);
    idle(1, "boot6");
    applyStimulus(1, 0, 0, 0, 1, 0, 0, "retAfterReset");

    $display("[TB] random phase");
    for (int i = 0; i < 400; i++) begin
      rnd = ($urandom_range(0, 19) != 0);
      applyStimulus(rnd, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 60) == 0, int'($urandom_range(0, 31)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
